bitstream_decoder: RTL

- Stochastic-to-binary converter at the output end of the bitstream network.
- Counts '1' bits on each network output bitstream over a fixed window of WINDOW_LEN cycles.
- Presents the per-channel counts as binary results through a valid/ready handshake.
- Downstream logic, for example a CPU register or a UART packer, reads the network's result value from this block.

---
 rtl/bitstream_decoder_pkg.sv | 26 ++
 rtl/bitstream_decoder_if.sv | 39 +++
 rtl/bitstream_decoder_counter.sv | 39 +++
 rtl/bitstream_decoder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/bitstream_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_pkg
//  Description : Shared types and constants for the bitstream decoder
//                (FSM state encoding, default window length, width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package bitstream_pkg;

    // Decoder FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Weight stream length used by the network; default conversion window
    localparam int WEIGHT_LENGTH = 128;

    // Width needed to hold a count of 0..len inclusive
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage : bitstream_pkg
`default_nettype wire

// File: rtl/bitstream_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_decoder_if
//  Description : Request/bitstream/result bundle between the bitstream
//                network side and the decoder. master = driver of start,
//                bitstreams and result_ready; slave = the decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bitstream_decoder_if #(
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 8
);
    logic                      start;
    logic [CHANNELS-1:0]       bitstream_in;
    logic                      busy;
    logic                      result_valid;
    logic                      result_ready;
    logic [CHANNELS*CNT_W-1:0] result;

    modport master (
        output start,
        output bitstream_in,
        output result_ready,
        input  busy,
        input  result_valid,
        input  result
    );

    modport slave (
        input  start,
        input  bitstream_in,
        input  result_ready,
        output busy,
        output result_valid,
        output result
    );

endinterface : bitstream_decoder_if
`default_nettype wire

// File: rtl/bitstream_decoder_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_counter
//  Description : Single-channel ones counter. Clears on clear, adds one on
//                enable. count_next exposes the tally including the sample
//                presented this cycle so the final sample of a window can be
//                captured on the same edge that ends the window.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitstream_counter #(
    parameter int CNT_W = 8
) (
    input  wire              clk,
    input  wire              n_rst,
    input  wire              clear,
    input  wire              enable,
    output logic [CNT_W-1:0] count_next
);

    logic [CNT_W-1:0] r_count;

    // Running tally plus the current sample
    always_comb begin
        count_next = r_count + {{(CNT_W-1){1'b0}}, enable};
    end

    // Tally register; the window length bounds it, so no wrap handling
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= count_next;
        end
    end

endmodule : bitstream_counter
`default_nettype wire

// File: rtl/bitstream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bitstream_decoder
//  Description : Stochastic-to-binary converter. Counts ones on each channel
//                over WINDOW_LEN cycles, then holds the per-channel counts
//                behind a valid/ready handshake until consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int CHANNELS   = 1,
    parameter int WINDOW_LEN = WEIGHT_LENGTH,
    parameter int CNT_W      = cnt_width(WINDOW_LEN)
) (
    input  wire                 clk,
    input  wire                 n_rst,
    bitstream_decoder_if.slave  bus
);

    localparam int             CYC_W  = $clog2(WINDOW_LEN);
    localparam logic [CYC_W-1:0] C_LAST = CYC_W'(WINDOW_LEN - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CYC_W-1:0]          r_cycle;
    logic                      w_clear;
    logic                      w_load;
    logic                      w_last;
    logic [CHANNELS-1:0]       w_en;
    logic [CHANNELS*CNT_W-1:0] w_count_next;
    logic [CHANNELS*CNT_W-1:0] r_result;

    assign w_last = (r_cycle == C_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, counter clear and result load decode
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = ACCUM;
                    w_clear      = 1'b1;
                end
            end
            ACCUM: begin
                // start is deliberately ignored here: no restart, no queueing
                if (w_last) begin
                    w_state_next = HOLD;
                    w_load       = 1'b1;
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    if (bus.start) begin
                        // Back-to-back conversion without an idle bubble
                        w_state_next = ACCUM;
                        w_clear      = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Cycle counter: index of the sample being taken within the window
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cycle <= '0;
        end else if (w_clear) begin
            r_cycle <= '0;
        end else if ((r_state == ACCUM) && !w_last) begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Gate samples with the state so an undriven bus outside ACCUM is inert
    always_comb begin
        w_en = {CHANNELS{r_state == ACCUM}} & bus.bitstream_in;
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
            bitstream_counter #(
                .CNT_W (CNT_W)
            ) u_counter (
                .clk        (clk),
                .n_rst      (n_rst),
                .clear      (w_clear),
                .enable     (w_en[k]),
                .count_next (w_count_next[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Result register: captures counts including the final sample
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_result <= '0;
        end else if (w_load) begin
            r_result <= w_count_next;
        end
    end

    assign bus.busy         = (r_state == ACCUM);
    assign bus.result_valid = (r_state == HOLD);
    assign bus.result       = r_result;

endmodule : bitstream_decoder
`default_nettype wire
